ahb_sram_sub: RTL and testbench

//  AHB-Lite subordinate that consumes the transfers ahbinterface/ebu drive (NONSEQ, data phase 1 cycle after address)
//  and fronts a single-port synchronous SRAM (1-cycle read latency). Zero-wait reads by default, 1-entry posted

---
 rtl/ahb_sram_pkg.sv | 21 ++
 rtl/ahb_sram_wbuf.sv | 72 +++++++
 rtl/ahb_sram_sub.sv | 135 +++++++++++++
 tb/tb_ahb_sram_sub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared types for the AHB-Lite SRAM subordinate: transfer encodings and data-phase states.
package ahb_sram_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      IDLE,
      RDATA,
      WDATA
   } statetype;

   function automatic logic htrans_active(input logic [1:0] t);
      return (t == HT_NONSEQ) || (t == HT_SEQ);
   endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer with byte-wise forwarding onto SRAM read data.
// Load takes priority over drain so a drain+load cycle leaves the new entry valid.
module ahb_sram_wbuf #(
   parameter int XLEN       = 64,
   parameter int DEPTH_BITS = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  drain_i,
   input  logic [DEPTH_BITS-1:0] ld_addr_i,
   input  logic [XLEN-1:0]       ld_data_i,
   input  logic [XLEN/8-1:0]     ld_strb_i,
   input  logic [DEPTH_BITS-1:0] rd_addr_i,
   input  logic [XLEN-1:0]       ram_data_i,
   output logic                  valid_o,
   output logic [DEPTH_BITS-1:0] addr_o,
   output logic [XLEN-1:0]       data_o,
   output logic [XLEN/8-1:0]     strb_o,
   output logic [XLEN-1:0]       merged_o
);

   logic                  valid_q, valid_d;
   logic [DEPTH_BITS-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       data_q, data_d;
   logic [XLEN/8-1:0]     strb_q, strb_d;
   logic                  hit;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      if (load_i) begin
         valid_d = 1'b1;
         addr_d  = ld_addr_i;
         data_d  = ld_data_i;
         strb_d  = ld_strb_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
      end
   end

   assign hit = valid_q && (addr_q == rd_addr_i);

   always_comb begin
      merged_o = ram_data_i;
      for (int i = 0; i < XLEN/8; i++) begin
         if (hit && strb_q[i]) merged_o[8*i +: 8] = data_q[8*i +: 8];
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign strb_o  = strb_q;

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate in front of a 1-cycle synchronous SRAM: zero-wait reads (plus READ_WAIT),
// posted writes with one wait only when the buffer is still occupied; HREADYOUT is purely registered.
module ahb_sram_sub
   import ahb_sram_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int PA_BITS    = 32,
   parameter int DEPTH_BITS = 12,
   parameter int READ_WAIT  = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [PA_BITS-1:0]    HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [XLEN-1:0]       HWDATA,
   input  logic [XLEN/8-1:0]     HWSTRB,
   output logic [XLEN-1:0]       HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic                  RamEn,
   output logic                  RamWE,
   output logic [DEPTH_BITS-1:0] RamAddr,
   output logic [XLEN/8-1:0]     RamByteEn,
   output logic [XLEN-1:0]       RamWriteData,
   input  logic [XLEN-1:0]       RamReadData
);

   localparam int         OFS = $clog2(XLEN/8);
   localparam logic [3:0] RW  = 4'(READ_WAIT);

   statetype              state_q, state_d;
   logic [DEPTH_BITS-1:0] addr_q, addr_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic                  rd_first_q, rd_first_d;
   logic [XLEN-1:0]       rdreg_q, rdreg_d;

   logic [DEPTH_BITS-1:0] haddr_word;
   logic                  accept, rd_issue, drain, wr_done, ready;
   logic                  wb_valid;
   logic [DEPTH_BITS-1:0] wb_addr;
   logic [XLEN-1:0]       wb_data, merged;
   logic [XLEN/8-1:0]     wb_strb;
   logic                  unused_addr_bits;

   // Bits outside the word index are decoded upstream or implied by the strobes.
   assign unused_addr_bits = ^{HADDR[PA_BITS-1:DEPTH_BITS+OFS], HADDR[OFS-1:0]};

   assign haddr_word = HADDR[DEPTH_BITS+OFS-1:OFS];
   assign accept     = HSEL & htrans_active(HTRANS) & HREADY;
   assign rd_issue   = accept & ~HWRITE;
   assign drain      = wb_valid & ~rd_issue;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      rd_first_d = 1'b0;
      rdreg_d    = rdreg_q;
      ready      = 1'b1;
      HRDATA     = '0;
      wr_done    = 1'b0;
      case (state_q)
         RDATA: begin
            ready  = (wcnt_q == 4'd0);
            HRDATA = rd_first_q ? merged : rdreg_q;
            if (rd_first_q) rdreg_d = merged;
            if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
         end
         WDATA: begin
            ready   = ~wb_valid;
            wr_done = ~wb_valid;
         end
         default: ;
      endcase
      if (ready) begin
         if (accept) begin
            state_d    = HWRITE ? WDATA : RDATA;
            addr_d     = haddr_word;
            rd_first_d = ~HWRITE;
            wcnt_d     = HWRITE ? 4'd0 : RW;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wcnt_q     <= '0;
         rd_first_q <= 1'b0;
         rdreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         rd_first_q <= rd_first_d;
         rdreg_q    <= rdreg_d;
      end
   end

   ahb_sram_wbuf #(
      .XLEN       (XLEN),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_wbuf (
      .clk_i      (HCLK),
      .rst_i      (HRESET),
      .load_i     (wr_done),
      .drain_i    (drain),
      .ld_addr_i  (addr_q),
      .ld_data_i  (HWDATA),
      .ld_strb_i  (HWSTRB),
      .rd_addr_i  (addr_q),
      .ram_data_i (RamReadData),
      .valid_o    (wb_valid),
      .addr_o     (wb_addr),
      .data_o     (wb_data),
      .strb_o     (wb_strb),
      .merged_o   (merged)
   );

   // Reads always win the single SRAM port; the buffered write waits a cycle.
   assign RamEn        = rd_issue | drain;
   assign RamWE        = drain;
   assign RamAddr      = rd_issue ? haddr_word : wb_addr;
   assign RamByteEn    = drain ? wb_strb : '0;
   assign RamWriteData = wb_data;
   assign HREADYOUT    = ready;
   assign HRESP        = 1'b0;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Bench for ahb_sram_sub: two instances (READ_WAIT 0 and 2), each with its own SRAM model,
// checked against an architectural memory model where a read returns the latest completed write.
module tb_ahb_sram_sub;

   localparam int K_IDLE = 0, K_BUSY = 1, K_UNSEL = 2, K_RD = 3, K_WR = 4;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } op_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mem_clr;
   logic        hsel[2], hwrite[2], hreadyout[2], hresp[2], ram_en[2], ram_we[2];
   logic [31:0] haddr[2];
   logic [1:0]  htrans[2];
   logic [63:0] hwdata[2], hrdata[2], ram_wd[2], ram_rd[2];
   logic [7:0]  hwstrb[2], ram_be[2];
   logic [11:0] ram_addr[2], last_waddr[2];
   logic [63:0] sram[2][4096];
   logic [63:0] ref_mem[2][4096];
   int          wr_cnt[2], rd_cnt[2];

   logic        dp_rd[2];
   logic [63:0] exp_rd[2];
   int          dp_cyc[2];
   op_t         ops[$];
   int          waits_q[$];
   int          checks, failures;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ahb_sram_sub #(
         .XLEN(64), .PA_BITS(32), .DEPTH_BITS(12), .READ_WAIT(g * 2)
      ) u_dut (
         .HCLK(clk), .HRESET(rst), .HSEL(hsel[g]), .HADDR(haddr[g]), .HTRANS(htrans[g]),
         .HWRITE(hwrite[g]), .HREADY(hreadyout[g]), .HWDATA(hwdata[g]), .HWSTRB(hwstrb[g]),
         .HRDATA(hrdata[g]), .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]),
         .RamEn(ram_en[g]), .RamWE(ram_we[g]), .RamAddr(ram_addr[g]), .RamByteEn(ram_be[g]),
         .RamWriteData(ram_wd[g]), .RamReadData(ram_rd[g])
      );
   end

   // SRAM model: 1-cycle read latency, read data held until the next read.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 2; i++) begin
            wr_cnt[i] <= 0;
            rd_cnt[i] <= 0;
            last_waddr[i] <= '0;
            ram_rd[i] <= '0;
            for (int a = 0; a < 4096; a++) sram[i][a] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ram_en[i]) begin
               if (ram_we[i]) begin
                  for (int b = 0; b < 8; b++)
                     if (ram_be[i][b]) sram[i][ram_addr[i]][8*b +: 8] <= ram_wd[i][8*b +: 8];
                  wr_cnt[i] <= wr_cnt[i] + 1;
                  last_waddr[i] <= ram_addr[i];
               end else begin
                  ram_rd[i] <= sram[i][ram_addr[i]];
                  rd_cnt[i] <= rd_cnt[i] + 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] word(input logic [31:0] a);
      return a[14:3];
   endfunction

   function automatic op_t mk(input int k, input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] s);
      op_t o;
      o.kind = k; o.addr = a; o.data = d; o.strb = s;
      return o;
   endfunction

   task automatic model_write(input int i, input op_t o);
      for (int b = 0; b < 8; b++)
         if (o.strb[b]) ref_mem[i][word(o.addr)][8*b +: 8] = o.data[8*b +: 8];
   endtask

   task automatic drive_addr(input int i, input op_t o);
      haddr[i] = o.addr;
      case (o.kind)
         K_IDLE:  begin hsel[i] = 1'b1; htrans[i] = 2'b00; hwrite[i] = 1'b1; end
         K_BUSY:  begin hsel[i] = 1'b1; htrans[i] = 2'b01; hwrite[i] = 1'b1; end
         K_UNSEL: begin hsel[i] = 1'b0; htrans[i] = 2'b10; hwrite[i] = 1'b1; end
         K_RD:    begin hsel[i] = 1'b1; htrans[i] = 2'b10; hwrite[i] = 1'b0; end
         default: begin hsel[i] = 1'b1; htrans[i] = 2'b10; hwrite[i] = 1'b1; end
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pipelined AHB master: runs the op queue on DUT i; called and returns at posedge+1.
   task automatic run_ops(input int i);
      op_t cur, dp, nop;
      logic dp_vld, rdy;
      int w, budget;
      nop = mk(K_IDLE, 32'h0, 64'h0, 8'h0);
      dp = nop; dp_vld = 1'b0; w = 0; budget = 0;
      cur = (ops.size() > 0) ? ops.pop_front() : nop;
      drive_addr(i, cur);
      while ((ops.size() > 0 || cur.kind >= K_RD || dp_vld) && budget < 200) begin
         @(negedge clk);
         rdy = hreadyout[i];
         @(posedge clk);
         #1;
         budget++;
         if (rdy) begin
            if (dp_vld) begin
               waits_q.push_back(w);
               if (dp.kind == K_WR) model_write(i, dp);
            end
            dp = cur;
            dp_vld = (cur.kind >= K_RD);
            w = 0;
            dp_cyc[i] = 0;
            dp_rd[i] = (cur.kind == K_RD);
            if (cur.kind == K_RD) exp_rd[i] = ref_mem[i][word(cur.addr)];
            hwdata[i] = cur.data;
            hwstrb[i] = cur.strb;
            cur = (ops.size() > 0) ? ops.pop_front() : nop;
            drive_addr(i, cur);
         end else begin
            w++;
            dp_cyc[i]++;
         end
      end
      chk("run_budget", 64'(budget < 200), 64'd1);
   endtask

   task automatic chk_waits(input string n, input int cnt, input int w0, input int w1, input int w2);
      chk({n, "_count"}, 64'(waits_q.size()), 64'(cnt));
      for (int k = 0; k < cnt && k < waits_q.size(); k++)
         chk($sformatf("%s_w%0d", n, k), 64'(waits_q[k]), 64'((k == 0) ? w0 : (k == 1) ? w1 : w2));
      waits_q.delete();
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("hresp%0d", i), 64'(hresp[i]), 64'd0);
         if (dp_rd[i]) begin
            if (hreadyout[i] || dp_cyc[i] > 0)
               chk($sformatf("hrdata%0d", i), hrdata[i], exp_rd[i]);
         end else begin
            chk($sformatf("hrdata_idle%0d", i), hrdata[i], 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0, rd0;
      checks = 0; failures = 0;
      rst = 1'b1; mem_clr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00; hwrite[i] = 1'b0;
         hwdata[i] = '0; hwstrb[i] = '0; dp_rd[i] = 1'b0; exp_rd[i] = '0; dp_cyc[i] = 0;
         for (int a = 0; a < 4096; a++) ref_mem[i][a] = '0;
      end
      idle(2);
      for (int i = 0; i < 2; i++) begin
         chk("rst_hreadyout", 64'(hreadyout[i]), 64'd1);
         chk("rst_hrdata", hrdata[i], 64'd0);
         chk("rst_ramen", 64'(ram_en[i]), 64'd0);
         chk("rst_hresp", 64'(hresp[i]), 64'd0);
      end
      mem_clr = 1'b0; rst = 1'b0;
      idle(1);

      // 1: full write, drain on the idle cycle, read back with zero waits
      ops.push_back(mk(K_WR, 32'h10, 64'h1122334455667788, 8'hFF));
      run_ops(0);
      chk("t1_drain_en", 64'(ram_en[0]), 64'd1);
      chk("t1_drain_we", 64'(ram_we[0]), 64'd1);
      chk("t1_drain_addr", 64'(ram_addr[0]), 64'd2);
      chk("t1_drain_be", 64'(ram_be[0]), 64'hFF);
      ops.push_back(mk(K_RD, 32'h10, 64'h0, 8'h0));
      run_ops(0);
      chk("t1_model", exp_rd[0], 64'h1122334455667788);
      chk_waits("t1", 2, 0, 0, 0);

      // 2: partial write then same-address read back-to-back: forwarding
      idle(2);
      ops.push_back(mk(K_WR, 32'h0, 64'hAAAAAAAAAAAAAAAA, 8'h0F));
      ops.push_back(mk(K_RD, 32'h0, 64'h0, 8'h0));
      run_ops(0);
      chk("t2_model", exp_rd[0], 64'h00000000AAAAAAAA);
      chk_waits("t2", 2, 0, 0, 0);
      idle(1);
      chk("t2_sram", sram[0][0], 64'h00000000AAAAAAAA);

      // 3: three back-to-back writes
      ops.push_back(mk(K_WR, 32'h08, 64'h0101010101010101, 8'hFF));
      ops.push_back(mk(K_WR, 32'h10, 64'h0202020202020202, 8'hFF));
      ops.push_back(mk(K_WR, 32'h18, 64'h0303030303030303, 8'hFF));
      run_ops(0);
      chk_waits("t3", 3, 0, 1, 1);
      idle(3);
      for (int k = 1; k <= 3; k++) chk($sformatf("t3_sram%0d", k), sram[0][k], ref_mem[0][k]);
      chk("t3_model", ref_mem[0][3], 64'h0303030303030303);

      // 5: non-transfers carrying write data must not load the buffer
      idle(2);
      wr0 = wr_cnt[0]; rd0 = rd_cnt[0];
      ops.push_back(mk(K_WR, 32'h20, 64'h5555666677778888, 8'hFF));
      ops.push_back(mk(K_IDLE, 32'h28, 64'hDEADBEEFDEADBEEF, 8'hFF));
      ops.push_back(mk(K_BUSY, 32'h28, 64'hDEADBEEFDEADBEEF, 8'hFF));
      ops.push_back(mk(K_UNSEL, 32'h28, 64'hDEADBEEFDEADBEEF, 8'hFF));
      ops.push_back(mk(K_IDLE, 32'h28, 64'hDEADBEEFDEADBEEF, 8'hFF));
      run_ops(0);
      idle(3);
      chk("t5_wr_count", 64'(wr_cnt[0] - wr0), 64'd1);
      chk("t5_rd_count", 64'(rd_cnt[0] - rd0), 64'd0);
      chk("t5_waddr", 64'(last_waddr[0]), 64'd4);
      ops.push_back(mk(K_RD, 32'h28, 64'h0, 8'h0));
      ops.push_back(mk(K_RD, 32'h20, 64'h0, 8'h0));
      run_ops(0);
      chk("t5_model", exp_rd[0], 64'h5555666677778888);
      chk_waits("t5", 3, 0, 0, 0);

      // 4: READ_WAIT=2 instance: waits, drain during waits, forwarding into the held data
      ops.push_back(mk(K_WR, 32'h08, 64'h0123456789ABCDEF, 8'hFF));
      ops.push_back(mk(K_IDLE, 32'h0, 64'h0, 8'h0));
      ops.push_back(mk(K_IDLE, 32'h0, 64'h0, 8'h0));
      ops.push_back(mk(K_WR, 32'h18, 64'h3333333344444444, 8'hFF));
      ops.push_back(mk(K_RD, 32'h08, 64'h0, 8'h0));
      run_ops(1);
      chk_waits("t4a", 3, 0, 0, 2);
      chk("t4_drain_in_wait", sram[1][3], 64'h3333333344444444);
      ops.push_back(mk(K_WR, 32'h08, 64'hFFEEDDCCBBAA9988, 8'hF0));
      ops.push_back(mk(K_RD, 32'h08, 64'h0, 8'h0));
      run_ops(1);
      chk_waits("t4b", 2, 0, 2, 0);
      chk("t4_model", exp_rd[1], 64'hFFEEDDCC89ABCDEF);

      // 6: reset while the second write waits on an occupied buffer
      idle(2);
      wr0 = wr_cnt[0];
      drive_addr(0, mk(K_WR, 32'h28, 64'h0, 8'h0));
      idle(1);
      chk("t6_w1_rdy", 64'(hreadyout[0]), 64'd1);
      hwdata[0] = 64'h6666666666666666; hwstrb[0] = 8'hFF;
      drive_addr(0, mk(K_WR, 32'h30, 64'h0, 8'h0));
      idle(1);
      chk("t6_w2_wait", 64'(hreadyout[0]), 64'd0);
      hwdata[0] = 64'h7777777777777777;
      drive_addr(0, mk(K_IDLE, 32'h0, 64'h0, 8'h0));
      rst = 1'b1;
      #1;
      chk("t6_rst_rdy", 64'(hreadyout[0]), 64'd1);
      chk("t6_rst_ramen", 64'(ram_en[0]), 64'd0);
      chk("t6_rst_hrdata", hrdata[0], 64'd0);
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("t6_no_writes", 64'(wr_cnt[0] - wr0), 64'd0);
      chk("t6_sram5", sram[0][5], 64'd0);
      chk("t6_sram6", sram[0][6], 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
